fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: INIT/RUN/MISS PC sequencer driving imem and the IF/ID register.
// Latency: one edge from an accepted imem word to IF/ID. A redirect wins over stall, and a miss inserts bubbles.
// Optional FETCH_PERF_EN adds fetch_count/bubble_count. Backpressure: stall holds PC and IF/ID, and imem_ready=0 parks in MISS.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] start_pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] program_counter,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] if_id_pc4,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`else
    output logic [31:0] if_id_pc4
`endif
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_MISS = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_t;

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic        vld_q;
    if_id_t      if_id_q;

    logic        running;
    logic        do_redirect;
    logic        do_load;
    logic        do_bubble;
    logic [31:0] pc_plus4;

    assign running     = (state_q != ST_INIT);
    assign do_redirect = running && redirect_valid;
    assign do_load     = running && !redirect_valid && !stall && imem_ready;
    // Both a redirect and a miss clear the IF/ID valid bit, so both count as bubbles.
    assign do_bubble   = running && (redirect_valid || (!stall && !imem_ready));
    assign pc_plus4    = pc_q + 32'd4;

    assign imem_addr       = pc_q;
    assign imem_req        = running;
    assign program_counter = pc_q;
    assign if_id_valid     = vld_q;
    assign if_id_instr     = if_id_q.instr;
    assign if_id_pc        = if_id_q.pc;
    assign if_id_pc4       = if_id_q.pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            pc_q    <= 32'd0;
            vld_q   <= 1'b0;
            if_id_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    pc_q    <= {start_pc[31:2], 2'b00};
                    state_q <= ST_RUN;
                end
                default: begin
                    if (do_redirect) begin
                        pc_q    <= {redirect_pc[31:2], 2'b00};
                        vld_q   <= 1'b0;
                        state_q <= ST_RUN;
                    end else if (stall) begin
                        state_q <= state_q;
                    end else if (imem_ready) begin
                        if_id_q.instr <= imem_rdata;
                        if_id_q.pc    <= pc_q;
                        if_id_q.pc4   <= pc_plus4;
                        vld_q         <= 1'b1;
                        pc_q          <= pc_plus4;
                        state_q       <= ST_RUN;
                    end else begin
                        vld_q   <= 1'b0;
                        state_q <= ST_MISS;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (do_load)
                fetch_count <= fetch_count + 32'd1;
            if (do_bubble)
                bubble_count <= bubble_count + 32'd1;
        end
    end
`else
    logic unused_bubble;
    assign unused_bubble = do_load ^ do_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, reset corners and a randomized run against a reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] start_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] program_counter;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .start_pc(start_pc), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .program_counter(program_counter), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
`ifdef FETCH_PERF_EN
        .if_id_pc4(if_id_pc4), .fetch_count(fetch_count), .bubble_count(bubble_count)
`else
        .if_id_pc4(if_id_pc4)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
    endfunction

    // The instruction memory contents are a fixed function of the address.
    always_comb imem_rdata = mem_word(imem_addr);

    // Reference model: the fetch behaviour written directly from its rules.
    bit          m_booted;
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
    bit          m_v;
    logic [31:0] m_fc, m_bc;

    task automatic model_reset();
        m_booted = 0; m_pc = 0; m_v = 0; m_instr = 0; m_ifpc = 0; m_ifpc4 = 0;
        m_fc = 0; m_bc = 0;
    endtask

    task automatic model_edge();
        if (!m_booted) begin
            m_pc = start_pc & ~32'd3;
            m_booted = 1;
        end else if (redirect_valid) begin
            m_pc = redirect_pc & ~32'd3;
            m_v = 0;
            m_bc++;
        end else if (!stall) begin
            if (imem_ready) begin
                m_instr = mem_word(m_pc);
                m_ifpc  = m_pc;
                m_ifpc4 = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
                m_v     = 1;
                m_fc++;
            end else begin
                m_v = 0;
                m_bc++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("pc",      program_counter, m_pc);
        chk("addr",    imem_addr, m_pc);
        chk("req",     {31'd0, imem_req}, {31'd0, m_booted});
        chk("valid",   {31'd0, if_id_valid}, {31'd0, m_v});
        chk("instr",   if_id_instr, m_instr);
        chk("if_pc",   if_id_pc, m_ifpc);
        chk("if_pc4",  if_id_pc4, m_ifpc4);
`ifdef FETCH_PERF_EN
        chk("fcount",  fetch_count, m_fc);
        chk("bcount",  bubble_count, m_bc);
`endif
    endtask

    // Inputs are stable here; advance the model, take the edge, then compare.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc",    program_counter, 32'd0);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk_model();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          st;
        bit          rv;
        logic [31:0] rpc;
        bit          rdy;
        bit          e_v;
        logic [31:0] e_pc;
        logic [31:0] e_ifpc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0, 0, 32'h0,        1, 1, 32'd608,       32'd604};
        vecs[1]  = '{0, 0, 32'h0,        0, 0, 32'd608,       32'd604};
        vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'd608,       32'd604};
        vecs[3]  = '{0, 0, 32'h0,        0, 0, 32'd608,       32'd604};
        vecs[4]  = '{0, 0, 32'h0,        1, 1, 32'd612,       32'd608};
        vecs[5]  = '{1, 0, 32'h0,        1, 1, 32'd612,       32'd608};
        vecs[6]  = '{1, 1, 32'h403,      1, 0, 32'h400,       32'd608};
        vecs[7]  = '{0, 0, 32'h0,        1, 1, 32'h404,       32'h400};
        vecs[8]  = '{0, 1, 32'hFFFFFFFC, 1, 0, 32'hFFFFFFFC,  32'h400};
        vecs[9]  = '{0, 0, 32'h0,        1, 1, 32'h0,         32'hFFFFFFFC};
        vecs[10] = '{1, 0, 32'h0,        0, 1, 32'h0,         32'hFFFFFFFC};
        vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0,         32'hFFFFFFFC};
        vecs[12] = '{0, 1, 32'h101,      0, 0, 32'h100,       32'hFFFFFFFC};
        vecs[13] = '{0, 0, 32'h0,        1, 1, 32'h104,       32'h100};

        rst = 1'b1; start_pc = 32'd600; stall = 0; redirect_valid = 0;
        redirect_pc = 0; imem_ready = 1;
        model_reset();
        #3;
        chk("reset_pc", program_counter, 32'd0);
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset_ifpc4", if_id_pc4, 32'd0);
        chk_model();
        @(posedge clk); #1;
        rst = 1'b0;

        // Boot from 600
        chk("init_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("boot_addr", imem_addr, 32'd600);
        step();
        chk("boot_ifpc", if_id_pc, 32'd600);
        chk("boot_ifpc4", if_id_pc4, 32'd604);
        chk("boot_pc", program_counter, 32'd604);

        for (int i = 0; i < 14; i++) begin
            stall = vecs[i].st; redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc; imem_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("vec%0d_pc", i), program_counter, vecs[i].e_pc);
            chk($sformatf("vec%0d_ifpc", i), if_id_pc, vecs[i].e_ifpc);
            chk($sformatf("vec%0d_ifpc4", i), if_id_pc4, vecs[i].e_ifpc + 32'd4);
            chk($sformatf("vec%0d_instr", i), if_id_instr, mem_word(vecs[i].e_ifpc));
        end

        // Async reset while parked in MISS, then reboot from a new start address
        stall = 0; redirect_valid = 0; imem_ready = 0;
        step();
        step();
        async_reset_pulse();
        start_pc = 32'h0000_1003;
        imem_ready = 1;
        step();
        chk("reboot_pc", program_counter, 32'h0000_1000);
        for (int i = 0; i < 10; i++) step();
`ifdef FETCH_PERF_EN
        chk("perf_fetch10", fetch_count, 32'd10);
`endif

        // Async reset during a stall
        stall = 1;
        step();
        async_reset_pulse();
        stall = 0;

        for (int i = 0; i < 600; i++) begin
            stall          = ($urandom_range(3) == 0);
            redirect_valid = ($urandom_range(7) == 0);
            redirect_pc    = ($urandom_range(5) == 0) ? 32'hFFFFFFFC : $urandom();
            imem_ready     = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) start_pc = $urandom();
            step();
            if ($urandom_range(63) == 0) async_reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
